squarewave_multi: RTL and testbench

Parametrised, multi-channel successor to the single-channel square-wave generator. Each channel drives an output that is high for m time units and low for n time units. One time unit is TICK_DIV clock cycles. Each channel has its own enable. New m/n values are latched only at period boundaries, so changing them never produces glitched or truncated phases. The block sits between the control registers and the pins or downstream logic that need programmable pulse trains.

---
 rtl/squarewave_pkg.sv | 33 +++
 rtl/squarewave_channel.sv | 135 +++++++++++++
 rtl/squarewave_multi.sv | 46 ++++
 tb/tb_squarewave_multi.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/squarewave_pkg.sv
// Shared types, default parameters and helpers for the squarewave_multi generator.
// The optional simultaneous-restart input is enabled with SQUAREWAVE_SYNC_EN.
package squarewave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } sw_state_e;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_WIDTH    = 4;
  localparam int DEF_TICK_DIV = 5;

  // Wide enough for (2^width - 1) * tick_div cycles, so a phase never wraps.
  function automatic int cnt_width(input int width, input int tick_div);
    return width + $clog2(tick_div) + 1;
  endfunction

  // State entered after loading new m/n: high phase first, then low, else stay idle.
  function automatic sw_state_e latch_state(input logic m_nonzero, input logic n_nonzero);
    sw_state_e st;
    if (m_nonzero) begin
      st = ST_HIGH;
    end else if (n_nonzero) begin
      st = ST_LOW;
    end else begin
      st = ST_IDLE;
    end
    return st;
  endfunction

endpackage

// File: rtl/squarewave_channel.sv
// One square-wave channel: IDLE/HIGH/LOW FSM, m/n shadow registers and phase counter.
// With SQUAREWAVE_SYNC_EN a sync strobe forces a reload regardless of the current phase.
module squarewave_channel
  import squarewave_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SQUAREWAVE_SYNC_EN
  input  logic             sync,
`endif
  input  logic             en,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] n,
  output logic             w,
  output logic             period_done
);

  localparam int CW = cnt_width(WIDTH, TICK_DIV);
  localparam logic [WIDTH-1:0] FIELD_ZERO = {WIDTH{1'b0}};
  localparam logic [CW-1:0]    CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    TICK_W     = CW'(TICK_DIV);

  sw_state_e        state_q, state_d;
  logic [WIDTH-1:0] m_s_q, m_s_d;
  logic [WIDTH-1:0] n_s_q, n_s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             w_q, w_d;
  logic             pd_q, pd_d;
  logic             latch_s;
  logic [CW-1:0]    phase_len_s;
  logic             phase_last_s;

  // Length of the current phase in clock cycles and whether this is its final cycle
  always_comb begin
    phase_len_s = CNT_ZERO;
    case (state_q)
      ST_HIGH: phase_len_s = {{(CW-WIDTH){1'b0}}, m_s_q} * TICK_W;
      ST_LOW:  phase_len_s = {{(CW-WIDTH){1'b0}}, n_s_q} * TICK_W;
      default: phase_len_s = CNT_ZERO;
    endcase
    phase_last_s = (cnt_q == (phase_len_s - CNT_ONE));
  end

  // Next-state, shadow reload and output decode
  always_comb begin
    state_d = state_q;
    m_s_d   = m_s_q;
    n_s_d   = n_s_q;
    cnt_d   = cnt_q;
    pd_d    = 1'b0;
    latch_s = 1'b0;
    w_d     = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end
`ifdef SQUAREWAVE_SYNC_EN
    else if (sync) begin
      latch_s = 1'b1;
      pd_d    = (state_q != ST_IDLE);
    end
`endif
    else begin
      case (state_q)
        ST_IDLE: begin
          latch_s = 1'b1;
        end
        ST_HIGH: begin
          if (!phase_last_s) begin
            cnt_d = cnt_q + CNT_ONE;
          end else if (n_s_q != FIELD_ZERO) begin
            state_d = ST_LOW;
            cnt_d   = CNT_ZERO;
          end else begin
            latch_s = 1'b1;
            pd_d    = 1'b1;
          end
        end
        ST_LOW: begin
          if (!phase_last_s) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            latch_s = 1'b1;
            pd_d    = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    // A reload always restarts the counter and picks the first phase of the new period
    if (latch_s) begin
      m_s_d   = m;
      n_s_d   = n;
      cnt_d   = CNT_ZERO;
      state_d = latch_state(m != FIELD_ZERO, n != FIELD_ZERO);
    end else begin
      m_s_d = m_s_q;
      n_s_d = n_s_q;
    end

    w_d = (state_d == ST_HIGH);
  end

  // State, shadow, counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m_s_q   <= FIELD_ZERO;
      n_s_q   <= FIELD_ZERO;
      cnt_q   <= CNT_ZERO;
      w_q     <= 1'b0;
      pd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      m_s_q   <= m_s_d;
      n_s_q   <= n_s_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      pd_q    <= pd_d;
    end
  end

  assign w           = w_q;
  assign period_done = pd_q;

endmodule

// File: rtl/squarewave_multi.sv
// Multi-channel programmable square-wave generator; one squarewave_channel per output.
// Define SQUAREWAVE_SYNC_EN to add the sync port that phase-aligns all enabled channels.
module squarewave_multi
  import squarewave_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef SQUAREWAVE_SYNC_EN
  input  logic                      sync,
`endif
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] m,
  input  logic [CHANNELS*WIDTH-1:0] n,
  output logic [CHANNELS-1:0]       w,
  output logic [CHANNELS-1:0]       period_done
);

  logic [WIDTH-1:0] m_ch_s [CHANNELS];
  logic [WIDTH-1:0] n_ch_s [CHANNELS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign m_ch_s[gi] = m[gi*WIDTH +: WIDTH];
    assign n_ch_s[gi] = n[gi*WIDTH +: WIDTH];

    squarewave_channel #(
      .WIDTH    (WIDTH),
      .TICK_DIV (TICK_DIV)
    ) u_channel (
      .clk         (clk),
      .reset       (reset),
`ifdef SQUAREWAVE_SYNC_EN
      .sync        (sync),
`endif
      .en          (en[gi]),
      .m           (m_ch_s[gi]),
      .n           (n_ch_s[gi]),
      .w           (w[gi]),
      .period_done (period_done[gi])
    );
  end

endmodule

// File: tb/tb_squarewave_multi.sv
// Bench for squarewave_multi: period-position reference model compared every cycle,
// plus edge timestamps checked against hand-computed phase lengths.
module tb_squarewave_multi;

  localparam int CH = 4;
  localparam int W  = 4;
  localparam int TD = 5;
  localparam int NS = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     en;
  logic [CH*W-1:0]   m;
  logic [CH*W-1:0]   n;
  logic              sync_tb;
  logic [CH-1:0]     w;
  logic [CH-1:0]     pd;

  always #10 clk = ~clk;

  squarewave_multi #(.CHANNELS(CH), .WIDTH(W), .TICK_DIV(TD)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef SQUAREWAVE_SYNC_EN
    .sync        (sync_tb),
`endif
    .en          (en),
    .m           (m),
    .n           (n),
    .w           (w),
    .period_done (pd)
  );

  // Model: position t within the current period plus the latched m/n of that period
  typedef struct packed {
    logic active;
    int   t;
    int   ms;
    int   ns;
    logic w;
    logic pd;
  } mdl_t;

  mdl_t mdl [CH];

  function automatic mdl_t mdl_step(input mdl_t s, input logic rst, input logic e,
                                    input int mv, input int nv, input logic sy);
    mdl_t r;
    logic ld;
    r = s;
    r.pd = 1'b0;
    ld = 1'b0;
    if (rst || !e) begin
      r.active = 1'b0;
      r.t = 0;
      r.ms = 0;
      r.ns = 0;
      r.w = 1'b0;
      return r;
    end
    if (sy) begin
      r.pd = s.active;
      ld = 1'b1;
    end else if (!s.active) begin
      ld = 1'b1;
    end else begin
      r.t = s.t + 1;
      if (r.t == (s.ms + s.ns) * TD) begin
        r.pd = 1'b1;
        ld = 1'b1;
      end
    end
    if (ld) begin
      r.ms = mv;
      r.ns = nv;
      r.t = 0;
      r.active = ((mv + nv) != 0);
    end
    r.w = r.active && (r.t < r.ms * TD);
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < CH; i++)
      mdl[i] <= mdl_step(mdl[i], reset, en[i], int'(m[i*W +: W]), int'(n[i*W +: W]), sync_tb);
  end

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;
  bit rec_on = 1'b0;
  int rec_cyc = 0;
  logic [CH-1:0] prev_w;
  int rise_t [CH][NS];
  int fall_t [CH][NS];
  int pd_t   [CH][NS];
  int rise_n [CH];
  int fall_n [CH];
  int pd_n   [CH];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one cycle; compare against the model and log edges at the falling clock
  task automatic step();
    logic [CH-1:0] ew;
    logic [CH-1:0] ep;
    @(negedge clk);
    for (int i = 0; i < CH; i++) begin
      ew[i] = mdl[i].w;
      ep[i] = mdl[i].pd;
    end
    if (cmp_on) begin
      checks++;
      if (w !== ew || pd !== ep) begin
        errors++;
        if (errors <= 20)
          $display("FAIL model_cmp @%0t: w=%b pd=%b, expected w=%b pd=%b", $time, w, pd, ew, ep);
      end
    end
    if (rec_on) begin
      for (int i = 0; i < CH; i++) begin
        if (w[i] && !prev_w[i]) begin
          if (rise_n[i] < NS) rise_t[i][rise_n[i]] = rec_cyc;
          rise_n[i]++;
        end
        if (!w[i] && prev_w[i]) begin
          if (fall_n[i] < NS) fall_t[i][fall_n[i]] = rec_cyc;
          fall_n[i]++;
        end
        if (pd[i]) begin
          if (pd_n[i] < NS) pd_t[i][pd_n[i]] = rec_cyc;
          pd_n[i]++;
        end
      end
      prev_w = w;
      rec_cyc++;
    end
  endtask

  initial begin
    int cnt_pd;
    int cnt_w;
    reset = 1'b1;
    en = '0;
    m = '0;
    n = '0;
    sync_tb = 1'b0;
    prev_w = '0;
    for (int i = 0; i < CH; i++) begin
      rise_n[i] = 0;
      fall_n[i] = 0;
      pd_n[i] = 0;
      for (int k = 0; k < NS; k++) begin
        rise_t[i][k] = -1;
        fall_t[i][k] = -1;
        pd_t[i][k] = -1;
      end
    end

    step();
    step();
    cmp_on = 1'b1;
    step();
    chk("reset_w", int'(w), 0);
    chk("reset_pd", int'(pd), 0);
    reset = 1'b0;
    step();
    step();

    m = {4'd15, 4'd0, 4'd5, 4'd1};
    n = {4'd15, 4'd3, 4'd1, 4'd1};
    en = 4'hF;
    prev_w = '0;
    rec_cyc = 0;
    rec_on = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (c == 9) m[1*W +: W] = 4'd2;
      if (c == 29) en[3] = 1'b0;
      if (c == 30) begin
        chk("ch3_en_off_w", int'(w[3]), 0);
        chk("ch3_en_off_pd", int'(pd[3]), 0);
        en[3] = 1'b1;
      end
      if (c == 31) chk("ch3_en_on_w", int'(w[3]), 1);
    end
    rec_on = 1'b0;

    chk("ch0_first_rise", rise_t[0][0], 0);
    chk("ch0_high_len", fall_t[0][0] - rise_t[0][0], 5);
    chk("ch0_low_len", rise_t[0][1] - fall_t[0][0], 5);
    chk("ch0_first_pd", pd_t[0][0], 10);
    chk("ch0_pd_gap", pd_t[0][1] - pd_t[0][0], 10);
    chk("ch1_high_len_p1", fall_t[1][0] - rise_t[1][0], 25);
    chk("ch1_low_len_p1", rise_t[1][1] - fall_t[1][0], 5);
    chk("ch1_high_len_p2", fall_t[1][1] - rise_t[1][1], 10);
    chk("ch1_first_pd", pd_t[1][0], 30);
    chk("ch1_pd_gap", pd_t[1][1] - pd_t[1][0], 15);
    chk("ch2_rises", rise_n[2], 0);
    chk("ch2_first_pd", pd_t[2][0], 15);
    chk("ch2_pd_gap", pd_t[2][1] - pd_t[2][0], 15);
    chk("ch3_en_off_fall", fall_t[3][0], 30);
    chk("ch3_restart_rise", rise_t[3][1], 31);
    chk("ch3_high_len", fall_t[3][1] - rise_t[3][1], 75);
    chk("ch3_low_len", rise_t[3][2] - fall_t[3][1], 75);
    chk("ch3_first_pd", pd_t[3][0], 181);

    // ch2 with m=n=0 ends its current period and then stays quiet
    n[2*W +: W] = 4'd0;
    for (int c = 0; c < 20; c++) step();
    cnt_pd = 0;
    cnt_w = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (pd[2]) cnt_pd++;
      if (w[2]) cnt_w++;
    end
    chk("ch2_zero_pd_count", cnt_pd, 0);
    chk("ch2_zero_w_count", cnt_w, 0);

    reset = 1'b1;
    step();
    chk("midreset_w", int'(w), 0);
    chk("midreset_pd", int'(pd), 0);
    reset = 1'b0;
    step();
    chk("reset_release_w", int'(w), 11);
    chk("reset_release_pd", int'(pd), 0);
    for (int c = 0; c < 12; c++) step();

`ifdef SQUAREWAVE_SYNC_EN
    en = 4'b0011;
    m[1*W +: W] = 4'd2;
    n[1*W +: W] = 4'd3;
    for (int c = 0; c < 7; c++) step();
    sync_tb = 1'b1;
    step();
    sync_tb = 1'b0;
    chk("sync_w", int'(w[1:0]), 3);
    chk("sync_pd", int'(pd[1:0]), 3);
    chk("sync_disabled_w", int'(w[3:2]), 0);
    for (int c = 0; c < 30; c++) step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
